// File: rtl/id_ex_stage_pkg.sv
// Shared definitions for the ID/EX stage: ALU operation codes, forward-select
// codes and the layout of the ID/EX pipeline register.
package id_ex_stage_pkg;

    localparam int DATA_W = 32;
    localparam int REG_W  = 5;
    localparam int ALU_W  = 4;

    // ALU operation codes. ALU_ADD is zero so a cleared register is a bubble.
    localparam logic [ALU_W-1:0] ALU_ADD  = 4'h0;
    localparam logic [ALU_W-1:0] ALU_SUB  = 4'h1;
    localparam logic [ALU_W-1:0] ALU_AND  = 4'h2;
    localparam logic [ALU_W-1:0] ALU_OR   = 4'h3;
    localparam logic [ALU_W-1:0] ALU_XOR  = 4'h4;
    localparam logic [ALU_W-1:0] ALU_NOR  = 4'h5;
    localparam logic [ALU_W-1:0] ALU_SLT  = 4'h6;
    localparam logic [ALU_W-1:0] ALU_SLTU = 4'h7;
    localparam logic [ALU_W-1:0] ALU_SLL  = 4'h8;
    localparam logic [ALU_W-1:0] ALU_SRL  = 4'h9;
    localparam logic [ALU_W-1:0] ALU_SRA  = 4'ha;
    localparam logic [ALU_W-1:0] ALU_LUI  = 4'hb;

    // Which source currently drives a forwarded operand.
    typedef enum logic [1:0] {
        FWD_NONE = 2'b00,
        FWD_MEM  = 2'b01,
        FWD_WB   = 2'b10
    } fwd_sel_e;

    // Everything the ID/EX register holds for one instruction.
    typedef struct packed {
        logic              valid;
        logic [ALU_W-1:0]  alu_control;
        logic [REG_W-1:0]  rs;
        logic [REG_W-1:0]  rt;
        logic [REG_W-1:0]  dest;
        logic [DATA_W-1:0] rs_data;
        logic [DATA_W-1:0] rt_data;
        logic [DATA_W-1:0] imm;
        logic [REG_W-1:0]  shamt;
        logic              src_shamt;
        logic              src_imm;
        logic              reg_write;
        logic              mem_read;
        logic              mem_write;
        logic              mem_to_reg;
    } id_ex_t;

    // A bubble: no side effects downstream, harmless ADD of zeros.
    localparam id_ex_t ID_EX_BUBBLE = '{
        valid:       1'b0,
        alu_control: ALU_ADD,
        rs:          '0,
        rt:          '0,
        dest:        '0,
        rs_data:     '0,
        rt_data:     '0,
        imm:         '0,
        shamt:       '0,
        src_shamt:   1'b0,
        src_imm:     1'b0,
        reg_write:   1'b0,
        mem_read:    1'b0,
        mem_write:   1'b0,
        mem_to_reg:  1'b0
    };

endpackage

// File: rtl/id_ex_stage_fwd_select.sv
// fwd_select: resolves one source operand against the EX/MEM and MEM/WB
// results. The younger EX/MEM result wins; register 0 is never forwarded.
module fwd_select
    import id_ex_stage_pkg::*;
(
    input  logic [REG_W-1:0]  idx,
    input  logic [DATA_W-1:0] reg_val,
    input  logic              mem_reg_write,
    input  logic [REG_W-1:0]  mem_dest,
    input  logic [DATA_W-1:0] mem_result,
    input  logic              wb_reg_write,
    input  logic [REG_W-1:0]  wb_dest,
    input  logic [DATA_W-1:0] wb_result,
    output logic [DATA_W-1:0] val,
    output logic [1:0]        sel
);

    // Pick the newest in-flight producer of idx, else the register-file value.
    always_comb begin
        // NOTE: defaults first so every path assigns every output (no latch).
        val = reg_val;
        sel = FWD_NONE;
        if (idx != '0) begin
            if (mem_reg_write && (mem_dest == idx)) begin
                val = mem_result;
                sel = FWD_MEM;
            end else if (wb_reg_write && (wb_dest == idx)) begin
                val = wb_result;
                sel = FWD_WB;
            end
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register plus ALU operand select.
// Optional build macro ID_EX_FORWARD_EN enables EX/MEM and MEM/WB forwarding;
// without it the operands come straight from the registered read data.
module id_ex_stage
    import id_ex_stage_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              flush,
    input  logic              id_valid,
    input  logic [ALU_W-1:0]  id_alu_control,
    input  logic [REG_W-1:0]  id_rs,
    input  logic [REG_W-1:0]  id_rt,
    input  logic [REG_W-1:0]  id_dest,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [REG_W-1:0]  id_shamt,
    input  logic              id_src_shamt,
    input  logic              id_src_imm,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              id_mem_write,
    input  logic              id_mem_to_reg,
    input  logic              mem_reg_write,
    input  logic [REG_W-1:0]  mem_dest,
    input  logic [DATA_W-1:0] mem_result,
    input  logic              wb_reg_write,
    input  logic [REG_W-1:0]  wb_dest,
    input  logic [DATA_W-1:0] wb_result,
    output logic              ex_valid,
    output logic [ALU_W-1:0]  ex_alu_control,
    output logic [DATA_W-1:0] ex_a,
    output logic [DATA_W-1:0] ex_b,
    output logic [DATA_W-1:0] ex_store_data,
    output logic [REG_W-1:0]  ex_dest,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic              ex_mem_to_reg,
    output logic [1:0]        ex_fwd_a,
    output logic [1:0]        ex_fwd_b
);

    id_ex_t id_fields;
    id_ex_t r;

    logic [DATA_W-1:0] ra;
    logic [DATA_W-1:0] rt_val;

    assign id_fields = '{
        valid:       1'b1,
        alu_control: id_alu_control,
        rs:          id_rs,
        rt:          id_rt,
        dest:        id_dest,
        rs_data:     id_rs_data,
        rt_data:     id_rt_data,
        imm:         id_imm,
        shamt:       id_shamt,
        src_shamt:   id_src_shamt,
        src_imm:     id_src_imm,
        reg_write:   id_reg_write,
        mem_read:    id_mem_read,
        mem_write:   id_mem_write,
        mem_to_reg:  id_mem_to_reg
    };

    // Pipeline register: flush beats stall; stall holds; otherwise load or bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            r <= ID_EX_BUBBLE;
        end else if (flush) begin
            r <= ID_EX_BUBBLE;
        end else if (!stall) begin
            r <= id_valid ? id_fields : ID_EX_BUBBLE;
        end
    end

`ifdef ID_EX_FORWARD_EN
    fwd_select u_fwd_rs (
        .idx           (r.rs),
        .reg_val       (r.rs_data),
        .mem_reg_write (mem_reg_write),
        .mem_dest      (mem_dest),
        .mem_result    (mem_result),
        .wb_reg_write  (wb_reg_write),
        .wb_dest       (wb_dest),
        .wb_result     (wb_result),
        .val           (ra),
        .sel           (ex_fwd_a)
    );

    fwd_select u_fwd_rt (
        .idx           (r.rt),
        .reg_val       (r.rt_data),
        .mem_reg_write (mem_reg_write),
        .mem_dest      (mem_dest),
        .mem_result    (mem_result),
        .wb_reg_write  (wb_reg_write),
        .wb_dest       (wb_dest),
        .wb_result     (wb_result),
        .val           (rt_val),
        .sel           (ex_fwd_b)
    );
`else
    assign ra       = r.rs_data;
    assign rt_val   = r.rt_data;
    assign ex_fwd_a = FWD_NONE;
    assign ex_fwd_b = FWD_NONE;

    // Forwarding inputs and source indices have no consumer in this build.
    logic unused_fwd;
    assign unused_fwd = ^{mem_reg_write, mem_dest, mem_result,
                          wb_reg_write, wb_dest, wb_result, r.rs, r.rt};
`endif

    assign ex_valid       = r.valid;
    assign ex_alu_control = r.alu_control;
    assign ex_a           = r.src_shamt ? {27'b0, r.shamt} : ra;
    assign ex_b           = r.src_imm ? r.imm : rt_val;
    assign ex_store_data  = rt_val;
    assign ex_dest        = r.dest;

    // Side-effecting controls are gated by valid so a bubble never writes.
    assign ex_reg_write   = r.valid & r.reg_write;
    assign ex_mem_read    = r.valid & r.mem_read;
    assign ex_mem_write   = r.valid & r.mem_write;
    assign ex_mem_to_reg  = r.valid & r.mem_to_reg;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed cases from the stage's
// intended behaviour, then randomized traffic against a record-level model.
module tb_id_ex_stage;
    import id_ex_stage_pkg::*;

`ifdef ID_EX_FORWARD_EN
    localparam bit FWD_EN = 1'b1;
`else
    localparam bit FWD_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, flush, id_valid;
    logic [3:0]  id_alu_control;
    logic [4:0]  id_rs, id_rt, id_dest, id_shamt;
    logic [31:0] id_rs_data, id_rt_data, id_imm;
    logic        id_src_shamt, id_src_imm;
    logic        id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
    logic        mem_reg_write, wb_reg_write;
    logic [4:0]  mem_dest, wb_dest;
    logic [31:0] mem_result, wb_result;

    logic        ex_valid;
    logic [3:0]  ex_alu_control;
    logic [31:0] ex_a, ex_b, ex_store_data;
    logic [4:0]  ex_dest;
    logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;
    logic [1:0]  ex_fwd_a, ex_fwd_b;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
        .id_valid(id_valid), .id_alu_control(id_alu_control),
        .id_rs(id_rs), .id_rt(id_rt), .id_dest(id_dest),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
        .id_shamt(id_shamt), .id_src_shamt(id_src_shamt), .id_src_imm(id_src_imm),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
        .mem_reg_write(mem_reg_write), .mem_dest(mem_dest), .mem_result(mem_result),
        .wb_reg_write(wb_reg_write), .wb_dest(wb_dest), .wb_result(wb_result),
        .ex_valid(ex_valid), .ex_alu_control(ex_alu_control),
        .ex_a(ex_a), .ex_b(ex_b), .ex_store_data(ex_store_data), .ex_dest(ex_dest),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg),
        .ex_fwd_a(ex_fwd_a), .ex_fwd_b(ex_fwd_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model: the instruction now sitting in EX ----
    typedef struct {
        bit          valid;
        logic [3:0]  alu;
        logic [4:0]  rs, rt, dest, shamt;
        logic [31:0] rsd, rtd, imm;
        bit          ss, si, rw, mr, mw, m2r;
    } instr_t;

    function automatic instr_t bubble();
        instr_t b;
        b = '{default: '0};
        b.alu = ALU_ADD;
        return b;
    endfunction

    instr_t held = bubble();

    // Resolve one operand: returns {select, value} from the forwarding rules.
    function automatic logic [33:0] resolve(input logic [4:0] idx, input logic [31:0] v);
        if (FWD_EN && idx != 5'd0 && mem_reg_write && mem_dest == idx)
            return {2'd1, mem_result};
        if (FWD_EN && idx != 5'd0 && wb_reg_write && wb_dest == idx)
            return {2'd2, wb_result};
        return {2'd0, v};
    endfunction

    // What EX holds after each edge follows from flush/stall/valid priority.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) held = bubble();
        else if (flush) held = bubble();
        else if (stall) held = held;
        else if (!id_valid) held = bubble();
        else held = '{valid: 1'b1, alu: id_alu_control, rs: id_rs, rt: id_rt,
                      dest: id_dest, shamt: id_shamt, rsd: id_rs_data,
                      rtd: id_rt_data, imm: id_imm, ss: id_src_shamt,
                      si: id_src_imm, rw: id_reg_write, mr: id_mem_read,
                      mw: id_mem_write, m2r: id_mem_to_reg};
    end

    // Every cycle, compare all outputs against the model away from the edge.
    always @(negedge clk) begin
        logic [33:0] a_r, b_r;
        a_r = resolve(held.rs, held.rsd);
        b_r = resolve(held.rt, held.rtd);
        check("m_valid",   ex_valid,       held.valid);
        check("m_alu",     ex_alu_control, held.alu);
        check("m_a",       ex_a,           held.ss ? 32'(held.shamt) : a_r[31:0]);
        check("m_b",       ex_b,           held.si ? held.imm : b_r[31:0]);
        check("m_store",   ex_store_data,  b_r[31:0]);
        check("m_dest",    ex_dest,        held.dest);
        check("m_rw",      ex_reg_write,   held.valid && held.rw);
        check("m_mr",      ex_mem_read,    held.valid && held.mr);
        check("m_mw",      ex_mem_write,   held.valid && held.mw);
        check("m_m2r",     ex_mem_to_reg,  held.valid && held.m2r);
        check("m_fwd_a",   ex_fwd_a,       a_r[33:32]);
        check("m_fwd_b",   ex_fwd_b,       b_r[33:32]);
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic srcs_off();
        mem_reg_write = 0; mem_dest = 0; mem_result = 0;
        wb_reg_write = 0; wb_dest = 0; wb_result = 0;
    endtask

    task automatic load(input logic [3:0] alu, input logic [4:0] rs, rt, dest,
                        input logic [31:0] rsd, rtd, imm, input logic [4:0] sh,
                        input logic ss, si, rw, mr, mw, m2r);
        id_valid = 1; id_alu_control = alu; id_rs = rs; id_rt = rt; id_dest = dest;
        id_rs_data = rsd; id_rt_data = rtd; id_imm = imm; id_shamt = sh;
        id_src_shamt = ss; id_src_imm = si; id_reg_write = rw;
        id_mem_read = mr; id_mem_write = mw; id_mem_to_reg = m2r;
    endtask

    initial begin
        rst_n = 0; stall = 0; flush = 0;
        srcs_off();
        // Reset with a valid instruction presented and a r0 forward source live.
        load(ALU_ADD, 5'd1, 5'd2, 5'd3, 32'h5, 32'h7, 32'h0, 5'd0, 0, 0, 1, 0, 0, 0);
        mem_reg_write = 1; mem_dest = 0; mem_result = 32'hff;
        repeat (2) step();
        #1;
        check("rst_valid", ex_valid, 0);
        check("rst_alu", ex_alu_control, 4'h0);
        check("rst_a", ex_a, 0);
        check("rst_b", ex_b, 0);
        check("rst_store", ex_store_data, 0);
        check("rst_fwd_a", ex_fwd_a, 2'b00);
        check("rst_fwd_b", ex_fwd_b, 2'b00);
        rst_n = 1;
        srcs_off();

        // First edge after release captures ADD rs=1 (5), rt=2 (7).
        step();
        stall = 1;
        #1;
        check("add_valid", ex_valid, 1);
        check("add_a", ex_a, 32'h5);
        check("add_b", ex_b, 32'h7);
        check("add_dest", ex_dest, 5'd3);

        // Both sources match rs=1 during the stall: MEM wins, then WB.
        mem_reg_write = 1; mem_dest = 1; mem_result = 32'haa;
        wb_reg_write = 1; wb_dest = 1; wb_result = 32'hbb;
        #1;
        check("fwd_mem_a", ex_a, FWD_EN ? 32'haa : 32'h5);
        check("fwd_mem_sel", ex_fwd_a, FWD_EN ? 2'b01 : 2'b00);
        mem_reg_write = 0;
        #1;
        check("fwd_wb_a", ex_a, FWD_EN ? 32'hbb : 32'h5);
        check("fwd_wb_sel", ex_fwd_a, FWD_EN ? 2'b10 : 2'b00);

        // rs = r0 is never forwarded.
        stall = 0;
        srcs_off();
        load(ALU_OR, 5'd0, 5'd4, 5'd6, 32'h0, 32'h8, 32'h0, 5'd0, 0, 0, 1, 0, 0, 0);
        mem_reg_write = 1; mem_dest = 0; mem_result = 32'hff;
        step();
        #1;
        check("r0_a", ex_a, 0);
        check("r0_sel", ex_fwd_a, 2'b00);

        // SLL with shamt operand.
        srcs_off();
        load(ALU_SLL, 5'd3, 5'd6, 5'd7, 32'h99, 32'h40, 32'h0, 5'd4, 1, 0, 1, 0, 0, 0);
        step();
        #1;
        check("sll_a", ex_a, 32'h4);
        check("sll_b", ex_b, 32'h40);

        // Store: B takes imm, store data takes forwarded rt.
        load(ALU_ADD, 5'd8, 5'd5, 5'd0, 32'h100, 32'h1, 32'h10, 5'd0, 0, 1, 0, 0, 1, 0);
        mem_reg_write = 1; mem_dest = 5; mem_result = 32'h33;
        step();
        #1;
        check("st_a", ex_a, 32'h100);
        check("st_b", ex_b, 32'h10);
        check("st_data", ex_store_data, FWD_EN ? 32'h33 : 32'h1);
        check("st_mw", ex_mem_write, 1);

        // Stall two cycles with a different instruction offered.
        srcs_off();
        stall = 1;
        load(ALU_SUB, 5'd9, 5'd10, 5'd11, 32'h1234, 32'h5678, 32'h0, 5'd0, 0, 0, 1, 0, 0, 0);
        repeat (2) step();
        #1;
        check("stall_alu", ex_alu_control, ALU_ADD);
        check("stall_b", ex_b, 32'h10);
        check("stall_data", ex_store_data, 32'h1);
        check("stall_mw", ex_mem_write, 1);

        // Stall and flush together: flush wins.
        flush = 1;
        step();
        flush = 0; stall = 0; id_valid = 0;
        #1;
        check("flush_valid", ex_valid, 0);
        check("flush_rw", ex_reg_write, 0);
        check("flush_mw", ex_mem_write, 0);
        check("flush_b", ex_b, 0);

        // Randomized traffic; small index range makes forwarding matches common.
        for (int i = 0; i < 3000; i++) begin
            step();
            rst_n = ($urandom % 100) != 0;
            stall = ($urandom % 5) == 0;
            flush = ($urandom % 10) == 0;
            load(4'($urandom % 12), 5'($urandom % 8), 5'($urandom % 8), 5'($urandom),
                 $urandom, $urandom, $urandom, 5'($urandom),
                 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                 1'($urandom), 1'($urandom));
            id_valid = ($urandom % 4) != 0;
            mem_reg_write = 1'($urandom); mem_dest = 5'($urandom % 8); mem_result = $urandom;
            wb_reg_write = 1'($urandom); wb_dest = 5'($urandom % 8); wb_result = $urandom;
        end
        step();
        rst_n = 1;
        repeat (3) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
